// File: rtl/gsim_pkg.sv
// Shared widths and state encodings for the Gauss-Seidel x-result packer.
// Also holds the element one-hot helper that the bank uses for its valid mask.
package gsim_pkg;

    localparam int X_W       = 32;
    localparam int X_PER_MAT = 16;
    localparam int BEAT_W    = X_PER_MAT * X_W / 2;
    localparam int MAT_W     = 5;
    localparam int IDX_W     = 4;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2
    } bank_state_e;

    typedef enum logic [1:0] {
        DRN_IDLE  = 2'd0,
        DRN_BEAT0 = 2'd1,
        DRN_BEAT1 = 2'd2
    } drain_state_e;

    function automatic logic [X_PER_MAT-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        idx_onehot = {{(X_PER_MAT-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/gsim_x_bank.sv
// One ping-pong bank: element storage, valid mask, matrix tag and fill state.
// A release from the drain side takes effect before a same-cycle write.
module gsim_x_bank
    import gsim_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_wen,
    input  logic [MAT_W-1:0]          i_tag,
    input  logic [IDX_W-1:0]          i_idx,
    input  logic [X_W-1:0]            i_data,
    input  logic                      i_release,
    output bank_state_e               o_state,
    output logic                      o_empty_nxt,
    output logic [MAT_W-1:0]          o_tag,
    output logic [X_PER_MAT*X_W-1:0]  o_data,
    output logic                      o_drop,
    output logic                      o_dup
);

    bank_state_e                      state_q, state_d, st_eff_s;
    logic [X_PER_MAT-1:0]             mask_q, mask_d, mask_eff_s, bit_s;
    logic [MAT_W-1:0]                 tag_q, tag_d;
    logic [X_PER_MAT-1:0][X_W-1:0]    data_q, data_d;
    logic                             store_s, drop_s, dup_s;

    // Write/release rules: release first, then the write sees the resulting state.
    always_comb begin
        st_eff_s   = i_release ? BANK_EMPTY : state_q;
        mask_eff_s = i_release ? {X_PER_MAT{1'b0}} : mask_q;
        bit_s      = idx_onehot(i_idx);
        store_s    = 1'b0;
        drop_s     = 1'b0;
        dup_s      = 1'b0;
        state_d    = st_eff_s;
        mask_d     = mask_eff_s;
        tag_d      = tag_q;
        data_d     = data_q;
        if (i_wen) begin
            case (st_eff_s)
                BANK_EMPTY: begin
                    store_s = 1'b1;
                    tag_d   = i_tag;
                end
                BANK_FILL: begin
                    if (i_tag == tag_q) begin
                        store_s = 1'b1;
                        dup_s   = |(mask_eff_s & bit_s);
                    end else begin
                        drop_s = 1'b1;
                    end
                end
                BANK_FULL: drop_s = 1'b1;
                default: begin
                    drop_s  = 1'b1;
                    state_d = BANK_EMPTY;
                end
            endcase
        end else begin
            store_s = 1'b0;
        end
        if (store_s) begin
            data_d[i_idx] = i_data;
            mask_d        = mask_eff_s | bit_s;
            state_d       = (&mask_d) ? BANK_FULL : BANK_FILL;
        end else begin
            mask_d = mask_eff_s;
        end
    end

    // Bank state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= BANK_EMPTY;
            mask_q  <= {X_PER_MAT{1'b0}};
            tag_q   <= {MAT_W{1'b0}};
            data_q  <= {(X_PER_MAT*X_W){1'b0}};
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign o_state     = state_q;
    assign o_empty_nxt = (state_d == BANK_EMPTY);
    assign o_tag       = tag_q;
    assign o_data      = data_q;
    assign o_drop      = drop_s;
    assign o_dup       = dup_s;

endmodule

// File: rtl/gsim_x_packer.sv
// Gathers solver x writes into two banks and drains each full vector as two
// 256-bit beats over valid/ready; flags lost and duplicated element writes.
module gsim_x_packer
    import gsim_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_x_wen,
    input  logic [8:0]          i_x_addr,
    input  logic [X_W-1:0]      i_x_data,
    input  logic                i_proc_done,
    output logic                o_wr_vld,
    output logic [5:0]          o_wr_addr,
    output logic [BEAT_W-1:0]   o_wr_data,
    input  logic                i_wr_rdy,
    output logic                o_overflow,
    output logic                o_dup,
    output logic                o_all_done
);

    bank_state_e                     bank_state_s [2];
    logic [1:0]                      bank_full_s, empty_nxt_s, drop_s, dupw_s, release_s;
    logic [1:0][MAT_W-1:0]           bank_tag_s;
    logic [1:0][X_PER_MAT*X_W-1:0]   bank_data_s;

    drain_state_e                    drn_q, drn_d;
    logic                            ptr_q, ptr_d, sel_q, sel_d;
    logic                            vld_q, vld_d, ovf_q, ovf_d, dup_q, dup_d, done_q, done_d;
    logic [5:0]                      addr_q, addr_d;
    logic [BEAT_W-1:0]               data_q, data_d;
    logic                            take_s, pick_s;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        gsim_x_bank u_bank (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_wen       (i_x_wen && (i_x_addr[4] == 1'(b))),
            .i_tag       (i_x_addr[8:4]),
            .i_idx       (i_x_addr[3:0]),
            .i_data      (i_x_data),
            .i_release   (release_s[b]),
            .o_state     (bank_state_s[b]),
            .o_empty_nxt (empty_nxt_s[b]),
            .o_tag       (bank_tag_s[b]),
            .o_data      (bank_data_s[b]),
            .o_drop      (drop_s[b]),
            .o_dup       (dupw_s[b])
        );
        assign bank_full_s[b] = (bank_state_s[b] == BANK_FULL);
    end

    // Drain FSM next state, beat registers, sticky flags and done flag.
    always_comb begin
        drn_d     = drn_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        vld_d     = vld_q;
        addr_d    = addr_q;
        data_d    = data_q;
        release_s = 2'b00;
        take_s    = 1'b0;
        pick_s    = ptr_q;
        case (drn_q)
            DRN_IDLE: begin
                if (bank_full_s[ptr_q]) begin
                    take_s = 1'b1;
                    pick_s = ptr_q;
                end else if (bank_full_s[~ptr_q]) begin
                    take_s = 1'b1;
                    pick_s = ~ptr_q;
                end else begin
                    take_s = 1'b0;
                end
                if (take_s) begin
                    sel_d  = pick_s;
                    vld_d  = 1'b1;
                    addr_d = {bank_tag_s[pick_s], 1'b0};
                    data_d = bank_data_s[pick_s][BEAT_W-1:0];
                    drn_d  = DRN_BEAT0;
                end else begin
                    vld_d = 1'b0;
                end
            end
            DRN_BEAT0: begin
                if (i_wr_rdy) begin
                    addr_d = {bank_tag_s[sel_q], 1'b1};
                    data_d = bank_data_s[sel_q][2*BEAT_W-1:BEAT_W];
                    drn_d  = DRN_BEAT1;
                end else begin
                    drn_d = DRN_BEAT0;
                end
            end
            DRN_BEAT1: begin
                if (i_wr_rdy) begin
                    release_s[sel_q] = 1'b1;
                    ptr_d            = ~sel_q;
                    vld_d            = 1'b0;
                    drn_d            = DRN_IDLE;
                end else begin
                    drn_d = DRN_BEAT1;
                end
            end
            default: begin
                vld_d = 1'b0;
                drn_d = DRN_IDLE;
            end
        endcase
        ovf_d  = ovf_q | (|drop_s);
        dup_d  = dup_q | (|dupw_s);
        // Done looks at next-cycle state so it rises together with the final release.
        done_d = i_proc_done && (drn_d == DRN_IDLE) && (&empty_nxt_s);
    end

    // Drain FSM and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            drn_q  <= DRN_IDLE;
            ptr_q  <= 1'b0;
            sel_q  <= 1'b0;
            vld_q  <= 1'b0;
            addr_q <= 6'd0;
            data_q <= {BEAT_W{1'b0}};
            ovf_q  <= 1'b0;
            dup_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            drn_q  <= drn_d;
            ptr_q  <= ptr_d;
            sel_q  <= sel_d;
            vld_q  <= vld_d;
            addr_q <= addr_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
            dup_q  <= dup_d;
            done_q <= done_d;
        end
    end

    assign o_wr_vld   = vld_q;
    assign o_wr_addr  = addr_q;
    assign o_wr_data  = data_q;
    assign o_overflow = ovf_q;
    assign o_dup      = dup_q;
    assign o_all_done = done_q;

endmodule

// File: tb/tb_gsim_x_packer.sv
// Directed self-checking bench for gsim_x_packer: fill/drain, backpressure,
// overflow, duplicate, same-cycle release/refill, done and mid-drain reset.
module tb_gsim_x_packer;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_x_wen;
    logic [8:0]   i_x_addr;
    logic [31:0]  i_x_data;
    logic         i_proc_done;
    logic         o_wr_vld;
    logic [5:0]   o_wr_addr;
    logic [255:0] o_wr_data;
    logic         i_wr_rdy;
    logic         o_overflow;
    logic         o_dup;
    logic         o_all_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    gsim_x_packer dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_x_wen     (i_x_wen),
        .i_x_addr    (i_x_addr),
        .i_x_data    (i_x_data),
        .i_proc_done (i_proc_done),
        .o_wr_vld    (o_wr_vld),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .i_wr_rdy    (i_wr_rdy),
        .o_overflow  (o_overflow),
        .o_dup       (o_dup),
        .o_all_done  (o_all_done)
    );

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_x(input logic [4:0] mat, input logic [3:0] idx);
        return {7'd0, mat, idx, 16'd0};
    endfunction

    function automatic logic [255:0] exp_beat(input logic [4:0] mat, input int beat);
        logic [255:0] r;
        logic [3:0]   ix;
        r = 256'd0;
        for (int k = 0; k < 8; k++) begin
            ix = 4'(beat * 8 + k);
            r[k*32 +: 32] = exp_x(mat, ix);
        end
        return r;
    endfunction

    task automatic write_x(input logic [4:0] mat, input logic [3:0] idx, input logic [31:0] d);
        i_x_wen  = 1'b1;
        i_x_addr = {mat, idx};
        i_x_data = d;
        cyc();
        i_x_wen  = 1'b0;
        cyc();
    endtask

    task automatic write_mat(input logic [4:0] mat);
        for (int i = 0; i < 16; i++) write_x(mat, 4'(i), exp_x(mat, 4'(i)));
    endtask

    task automatic do_reset();
        i_reset     = 1'b1;
        i_x_wen     = 1'b0;
        i_wr_rdy    = 1'b0;
        i_proc_done = 1'b0;
        cyc();
        cyc();
        i_reset = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        int n;
        n = 0;
        while (!o_wr_vld && n < 300) begin
            cyc();
            n++;
        end
        check({tag, "_vld"}, 256'(o_wr_vld), 256'd1);
    endtask

    task automatic accept_beat(input string tag, input logic [5:0] addr, input logic [255:0] d);
        wait_vld(tag);
        check({tag, "_addr"}, 256'(o_wr_addr), 256'(addr));
        check({tag, "_data"}, o_wr_data, d);
        i_wr_rdy = 1'b1;
        cyc();
        i_wr_rdy = 1'b0;
    endtask

    logic [255:0] b0;

    initial begin
        i_reset = 1'b1; i_x_wen = 1'b0; i_x_addr = 9'd0; i_x_data = 32'd0;
        i_proc_done = 1'b0; i_wr_rdy = 1'b0;

        // Reset values
        do_reset();
        check("rst_vld",  256'(o_wr_vld),   256'd0);
        check("rst_addr", 256'(o_wr_addr),  256'd0);
        check("rst_data", o_wr_data,        256'd0);
        check("rst_ovf",  256'(o_overflow), 256'd0);
        check("rst_dup",  256'(o_dup),      256'd0);
        check("rst_done", 256'(o_all_done), 256'd0);

        // Matrix 0 fill, latency of 2 cycles after the completing write
        for (int i = 0; i < 15; i++) write_x(5'd0, 4'(i), exp_x(5'd0, 4'(i)));
        i_x_wen = 1'b1; i_x_addr = {5'd0, 4'd15}; i_x_data = exp_x(5'd0, 4'd15);
        cyc();
        i_x_wen = 1'b0;
        check("m0_lat_n1", 256'(o_wr_vld), 256'd0);
        cyc();
        check("m0_lat_n2", 256'(o_wr_vld), 256'd1);
        check("m0_b0_addr", 256'(o_wr_addr), 256'd0);
        check("m0_b0_data", o_wr_data, exp_beat(5'd0, 0));
        i_wr_rdy = 1'b1;
        cyc();
        check("m0_b1_vld",  256'(o_wr_vld), 256'd1);
        check("m0_b1_addr", 256'(o_wr_addr), 256'd1);
        check("m0_b1_data", o_wr_data, exp_beat(5'd0, 1));
        cyc();
        check("m0_end_vld", 256'(o_wr_vld), 256'd0);
        i_wr_rdy = 1'b0;
        check("m0_ovf", 256'(o_overflow), 256'd0);
        check("m0_dup", 256'(o_dup),      256'd0);

        // Four back-to-back matrices, ready held low 20 cycles per beat 0
        do_reset();
        fork
            begin
                for (int m = 0; m < 4; m++) write_mat(5'(m));
            end
            begin
                for (int m = 0; m < 4; m++) begin
                    wait_vld("s2_wait");
                    repeat (20) cyc();
                    accept_beat("s2_b0", 6'(2 * m),     exp_beat(5'(m), 0));
                    accept_beat("s2_b1", 6'(2 * m + 1), exp_beat(5'(m), 1));
                end
            end
        join
        check("s2_ovf", 256'(o_overflow), 256'd0);

        // Ready low 100 cycles while matrices 0,1,2 arrive: matrix 2 dropped
        do_reset();
        write_mat(5'd0);
        write_mat(5'd1);
        write_mat(5'd2);
        repeat (4) cyc();
        check("s3_ovf", 256'(o_overflow), 256'd1);
        accept_beat("s3_m0b0", 6'd0, exp_beat(5'd0, 0));
        accept_beat("s3_m0b1", 6'd1, exp_beat(5'd0, 1));
        accept_beat("s3_m1b0", 6'd2, exp_beat(5'd1, 0));
        accept_beat("s3_m1b1", 6'd3, exp_beat(5'd1, 1));
        i_wr_rdy = 1'b1;
        repeat (10) cyc();
        check("s3_no_m2", 256'(o_wr_vld), 256'd0);
        i_wr_rdy = 1'b0;

        // Duplicate write of index 5 keeps the later value
        do_reset();
        for (int i = 0; i < 5; i++) write_x(5'd0, 4'(i), exp_x(5'd0, 4'(i)));
        write_x(5'd0, 4'd5, 32'h0000AAAA);
        write_x(5'd0, 4'd5, 32'h00005555);
        for (int i = 6; i < 16; i++) write_x(5'd0, 4'(i), exp_x(5'd0, 4'(i)));
        check("s4_dup", 256'(o_dup),      256'd1);
        check("s4_ovf", 256'(o_overflow), 256'd0);
        b0 = exp_beat(5'd0, 0);
        b0[5*32 +: 32] = 32'h00005555;
        accept_beat("s4_b0", 6'd0, b0);
        accept_beat("s4_b1", 6'd1, exp_beat(5'd0, 1));

        // Bank 0 released in the same cycle as matrix 2's first write
        do_reset();
        write_mat(5'd0);
        write_mat(5'd1);
        accept_beat("s5_m0b0", 6'd0, exp_beat(5'd0, 0));
        check("s5_m0b1_addr", 256'(o_wr_addr), 256'd1);
        check("s5_m0b1_data", o_wr_data, exp_beat(5'd0, 1));
        i_wr_rdy = 1'b1;
        i_x_wen  = 1'b1; i_x_addr = {5'd2, 4'd0}; i_x_data = exp_x(5'd2, 4'd0);
        cyc();
        i_wr_rdy = 1'b0;
        i_x_wen  = 1'b0;
        cyc();
        for (int i = 1; i < 16; i++) write_x(5'd2, 4'(i), exp_x(5'd2, 4'(i)));
        accept_beat("s5_m1b0", 6'd2, exp_beat(5'd1, 0));
        accept_beat("s5_m1b1", 6'd3, exp_beat(5'd1, 1));
        accept_beat("s5_m2b0", 6'd4, exp_beat(5'd2, 0));
        accept_beat("s5_m2b1", 6'd5, exp_beat(5'd2, 1));
        check("s5_ovf", 256'(o_overflow), 256'd0);

        // Done held off while a beat is pending
        do_reset();
        write_mat(5'd0);
        wait_vld("s6_wait");
        i_proc_done = 1'b1;
        cyc();
        check("s6_done_b0", 256'(o_all_done), 256'd0);
        accept_beat("s6_b0", 6'd0, exp_beat(5'd0, 0));
        check("s6_done_b1", 256'(o_all_done), 256'd0);
        i_wr_rdy = 1'b1;
        cyc();
        i_wr_rdy = 1'b0;
        check("s6_vld_off", 256'(o_wr_vld),   256'd0);
        check("s6_done_on", 256'(o_all_done), 256'd1);
        i_proc_done = 1'b0;
        cyc();
        check("s6_done_off", 256'(o_all_done), 256'd0);

        // Reset in BEAT0 with both flags set discards everything
        write_x(5'd0, 4'd0, 32'h12345678);
        write_mat(5'd0);
        write_x(5'd0, 4'd3, 32'h0BADF00D);
        check("s7_vld",  256'(o_wr_vld),   256'd1);
        check("s7_dup",  256'(o_dup),      256'd1);
        check("s7_ovf",  256'(o_overflow), 256'd1);
        i_reset = 1'b1;
        cyc();
        check("s7_rst_vld", 256'(o_wr_vld),   256'd0);
        check("s7_rst_ovf", 256'(o_overflow), 256'd0);
        check("s7_rst_dup", 256'(o_dup),      256'd0);
        i_reset  = 1'b0;
        i_wr_rdy = 1'b1;
        repeat (5) cyc();
        check("s7_discard", 256'(o_wr_vld), 256'd0);
        i_wr_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
